// File: rtl/qar_irq_ctrl.sv
// qar_irq_ctrl: prioritised, nesting interrupt controller with a claim/complete
// register port that drives the external interrupt input of qar_core.
module qar_irq_ctrl #(
    parameter int NUM_SRC    = 8,
    parameter int PRIO_WIDTH = 3,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    src_irq,
    output logic [NUM_SRC-1:0]    src_ack,
    input  logic                  bus_valid,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [31:0]           bus_wdata,
    output logic                  bus_ready,
    output logic [31:0]           bus_rdata,
    output logic                  irq_out
);
    localparam int IDW = 5;
    localparam int WAW = ADDR_WIDTH - 2;

    typedef logic [PRIO_WIDTH-1:0] prio_t;

    logic [NUM_SRC-1:0] syncA_q, syncB_q, prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] insvc_q, insvc_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    prio_t              threshold_q, threshold_d;
    prio_t              prio_q [NUM_SRC];
    prio_t              prio_d [NUM_SRC];
    logic [IDW-1:0]     bestId_q, bestId_d;
    logic               irq_q;

    logic [WAW-1:0]     wordAddr;
    logic               rdEn, wrEn, claim;
    prio_t              floorPrio, bestPrio;
    logic [1:0]         unusedAddrBits;

    assign wordAddr       = bus_addr[ADDR_WIDTH-1:2];
    assign unusedAddrBits = bus_addr[1:0];
    assign rdEn           = bus_valid && !bus_we;
    assign wrEn           = bus_valid && bus_we;
    assign claim          = rdEn && (wordAddr == WAW'(4)) && (bestId_q != '0);
    assign bus_ready      = bus_valid;
    assign src_ack        = ack_q;
    assign irq_out        = irq_q;

    // A source must beat both the threshold and every priority already in
    // service; scanning upward with a strict compare keeps the lowest ID on ties.
    always_comb begin
        floorPrio = threshold_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (insvc_q[i] && (prio_q[i] > floorPrio)) floorPrio = prio_q[i];
        end
        bestPrio = floorPrio;
        bestId_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending_q[i] && enable_q[i] && !insvc_q[i] && (prio_q[i] > bestPrio)) begin
                bestPrio = prio_q[i];
                bestId_d = IDW'(i + 1);
            end
        end
    end

    always_comb begin
        enable_d    = enable_q;
        mode_d      = mode_q;
        threshold_d = threshold_q;
        insvc_d     = insvc_q;
        ack_d       = '0;
        for (int i = 0; i < NUM_SRC; i++) prio_d[i] = prio_q[i];

        if (wrEn) begin
            if (wordAddr == WAW'(1)) enable_d = bus_wdata[NUM_SRC-1:0];
            if (wordAddr == WAW'(2)) mode_d = bus_wdata[NUM_SRC-1:0];
            if (wordAddr == WAW'(3)) threshold_d = bus_wdata[PRIO_WIDTH-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (wordAddr == WAW'(8 + i)) prio_d[i] = bus_wdata[PRIO_WIDTH-1:0];
                if ((wordAddr == WAW'(4)) && (bus_wdata == 32'(i + 1)) && insvc_q[i]) begin
                    insvc_d[i] = 1'b0;
                    ack_d[i]   = 1'b1;
                end
            end
        end

        // A fresh edge on the claimed source survives the claim-time clear.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (claim && (bestId_q == IDW'(i + 1))) insvc_d[i] = 1'b1;
            if (mode_q[i]) begin
                pending_d[i] = (pending_q[i] && !(claim && (bestId_q == IDW'(i + 1))))
                               || (syncB_q[i] && !prev_q[i]);
            end else begin
                pending_d[i] = syncB_q[i] && !insvc_q[i];
            end
        end
    end

    always_comb begin
        bus_rdata = '0;
        if (rdEn) begin
            if (wordAddr == WAW'(0)) bus_rdata = 32'(pending_q);
            if (wordAddr == WAW'(1)) bus_rdata = 32'(enable_q);
            if (wordAddr == WAW'(2)) bus_rdata = 32'(mode_q);
            if (wordAddr == WAW'(3)) bus_rdata = 32'(threshold_q);
            if (wordAddr == WAW'(4)) bus_rdata = 32'(bestId_q);
            if (wordAddr == WAW'(5)) bus_rdata = 32'(insvc_q);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (wordAddr == WAW'(8 + i)) bus_rdata = 32'(prio_q[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncA_q     <= '0;
            syncB_q     <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            insvc_q     <= '0;
            ack_q       <= '0;
            threshold_q <= '0;
            bestId_q    <= '0;
            irq_q       <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
        end else begin
            syncA_q     <= src_irq;
            syncB_q     <= syncA_q;
            prev_q      <= syncB_q;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            insvc_q     <= insvc_d;
            ack_q       <= ack_d;
            threshold_q <= threshold_d;
            bestId_q    <= bestId_d;
            irq_q       <= (bestId_d != '0);
            for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= prio_d[i];
        end
    end

endmodule

// File: tb/tb_qar_irq_ctrl.sv
// Directed bench for qar_irq_ctrl: edge/level pending, priority and ties,
// nesting, threshold/disable, bad completes and asynchronous reset.
module tb_qar_irq_ctrl;
    localparam int NUM_SRC = 8;

    localparam logic [7:0] A_PEND  = 8'h00;
    localparam logic [7:0] A_EN    = 8'h04;
    localparam logic [7:0] A_MODE  = 8'h08;
    localparam logic [7:0] A_THR   = 8'h0C;
    localparam logic [7:0] A_CLAIM = 8'h10;
    localparam logic [7:0] A_INSVC = 8'h14;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_SRC-1:0] srcIrq = '0;
    logic [NUM_SRC-1:0] srcAck;
    logic               busValid = 1'b0;
    logic               busWe = 1'b0;
    logic [7:0]         busAddr = '0;
    logic [31:0]        busWdata = '0;
    logic               busReady;
    logic [31:0]        busRdata;
    logic               irqOut;

    int errors = 0;
    int checks = 0;

    qar_irq_ctrl #(.NUM_SRC(NUM_SRC), .PRIO_WIDTH(3), .ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_irq   (srcIrq),
        .src_ack   (srcAck),
        .bus_valid (busValid),
        .bus_we    (busWe),
        .bus_addr  (busAddr),
        .bus_wdata (busWdata),
        .bus_ready (busReady),
        .bus_rdata (busRdata),
        .irq_out   (irqOut)
    );

    always #5 clk = ~clk;

    // Every comparison funnels through here so the counts stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [7:0] a, input logic [31:0] d);
        busValid = v;
        busWe    = w;
        busAddr  = a;
        busWdata = d;
    endtask

    // Bus tasks start at a falling edge and return at the next falling edge.
    task automatic busWrite(input logic [7:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic checkRead(input string tag, input logic [7:0] a, input logic [31:0] expected);
        logic [31:0] d;
        applyStimulus(1'b1, 1'b0, a, 32'h0);
        #1 d = busRdata;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput(tag, d, expected);
    endtask

    task automatic doReset();
        rst    = 1'b1;
        srcIrq = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        $display("[TB] start");
        tick(2);
        checkOutput("rst_irq", 32'(irqOut), 32'h0);
        checkOutput("rst_ack", 32'(srcAck), 32'h0);
        checkOutput("rst_rdata_idle", busRdata, 32'h0);
        rst = 1'b0;
        tick(1);
        checkRead("rst_enable", A_EN, 32'h0);
        checkRead("rst_claim", A_CLAIM, 32'h0);

        // Basic edge-mode flow on source 3
        busWrite(8'h28, 32'h2);
        busWrite(A_EN, 32'h04);
        busWrite(A_MODE, 32'h04);
        checkRead("en_readback", A_EN, 32'h04);
        checkRead("prio3_readback", 8'h28, 32'h2);
        busWrite(8'h18, 32'hFFFF_FFFF);
        checkRead("unmapped_read", 8'h18, 32'h0);
        busWrite(A_PEND, 32'hFF);
        applyStimulus(1'b1, 1'b0, A_MODE, 32'h0);
        #1 checkOutput("bus_ready", 32'(busReady), 32'h1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
        srcIrq = 8'h04;
        tick(3);
        checkOutput("edge_irq_early", 32'(irqOut), 32'h0);
        tick(1);
        checkOutput("edge_irq_rise", 32'(irqOut), 32'h1);
        srcIrq = 8'h00;
        checkRead("edge_claim", A_CLAIM, 32'd3);
        checkRead("edge_pend_clr", A_PEND, 32'h0);
        checkRead("edge_insvc", A_INSVC, 32'h04);
        checkOutput("edge_irq_drop", 32'(irqOut), 32'h0);
        busWrite(A_CLAIM, 32'd3);
        checkOutput("edge_ack", 32'(srcAck), 32'h04);
        tick(1);
        checkOutput("edge_ack_end", 32'(srcAck), 32'h0);
        checkOutput("edge_irq_idle", 32'(irqOut), 32'h0);

        // Priority and tie-break: 4 (prio 6) then 1 and 2 (prio 5, low ID first)
        doReset();
        busWrite(8'h20, 32'd5);
        busWrite(8'h24, 32'd5);
        busWrite(8'h2C, 32'd6);
        busWrite(A_EN, 32'h0B);
        busWrite(A_MODE, 32'h0B);
        srcIrq = 8'h0B;
        tick(4);
        checkOutput("prio_irq", 32'(irqOut), 32'h1);
        srcIrq = 8'h00;
        checkRead("prio_claim4", A_CLAIM, 32'd4);
        busWrite(A_CLAIM, 32'd4);
        checkOutput("prio_ack4", 32'(srcAck), 32'h08);
        tick(1);
        checkRead("prio_claim1", A_CLAIM, 32'd1);
        tick(1);
        checkOutput("prio_tie_blocked", 32'(irqOut), 32'h0);
        busWrite(A_CLAIM, 32'd1);
        checkOutput("prio_ack1", 32'(srcAck), 32'h01);
        tick(1);
        checkRead("prio_claim2", A_CLAIM, 32'd2);

        // Nesting: 5 (prio 4) preempts 1 (prio 2); 2 (prio 2) waits for both
        doReset();
        busWrite(8'h20, 32'd2);
        busWrite(8'h24, 32'd2);
        busWrite(8'h30, 32'd4);
        busWrite(A_EN, 32'h13);
        busWrite(A_MODE, 32'h13);
        srcIrq = 8'h01;
        tick(4);
        checkOutput("nest_irq1", 32'(irqOut), 32'h1);
        srcIrq = 8'h00;
        checkRead("nest_claim1", A_CLAIM, 32'd1);
        tick(1);
        checkOutput("nest_idle1", 32'(irqOut), 32'h0);
        srcIrq = 8'h10;
        tick(4);
        checkOutput("nest_irq5", 32'(irqOut), 32'h1);
        srcIrq = 8'h00;
        checkRead("nest_claim5", A_CLAIM, 32'd5);
        srcIrq = 8'h02;
        tick(4);
        checkOutput("nest_src2_blocked", 32'(irqOut), 32'h0);
        srcIrq = 8'h00;
        checkRead("nest_insvc", A_INSVC, 32'h11);
        busWrite(A_CLAIM, 32'd5);
        checkOutput("nest_ack5", 32'(srcAck), 32'h10);
        tick(2);
        checkOutput("nest_still_blocked", 32'(irqOut), 32'h0);
        busWrite(A_CLAIM, 32'd1);
        checkOutput("nest_ack1", 32'(srcAck), 32'h01);
        tick(1);
        checkOutput("nest_irq2", 32'(irqOut), 32'h1);
        checkRead("nest_claim2", A_CLAIM, 32'd2);

        // Threshold and disable on level source 6 (prio 3)
        doReset();
        busWrite(8'h34, 32'd3);
        busWrite(A_EN, 32'h20);
        busWrite(A_THR, 32'd3);
        srcIrq = 8'h20;
        tick(5);
        checkOutput("thr_block", 32'(irqOut), 32'h0);
        checkRead("thr_pend", A_PEND, 32'h20);
        busWrite(A_THR, 32'd2);
        tick(1);
        checkOutput("thr_pass", 32'(irqOut), 32'h1);
        busWrite(A_EN, 32'h00);
        checkOutput("dis_one_cycle", 32'(irqOut), 32'h1);
        tick(1);
        checkOutput("dis_drop", 32'(irqOut), 32'h0);
        checkRead("dis_pend_kept", A_PEND, 32'h20);

        // Level re-pend and ignored completes on source 7 (prio 4)
        doReset();
        busWrite(8'h38, 32'd4);
        busWrite(A_EN, 32'h40);
        srcIrq = 8'h40;
        tick(4);
        checkOutput("lvl_irq", 32'(irqOut), 32'h1);
        checkRead("lvl_claim", A_CLAIM, 32'd7);
        tick(1);
        checkOutput("lvl_idle", 32'(irqOut), 32'h0);
        checkRead("lvl_pend_masked", A_PEND, 32'h0);
        busWrite(A_CLAIM, 32'd0);
        checkOutput("bad_ack0", 32'(srcAck), 32'h0);
        busWrite(A_CLAIM, 32'd9);
        checkOutput("bad_ack9", 32'(srcAck), 32'h0);
        busWrite(A_CLAIM, 32'd3);
        checkOutput("bad_ack3", 32'(srcAck), 32'h0);
        checkRead("bad_insvc", A_INSVC, 32'h40);
        busWrite(A_CLAIM, 32'd7);
        checkOutput("lvl_ack", 32'(srcAck), 32'h40);
        checkOutput("lvl_irq_c", 32'(irqOut), 32'h0);
        tick(1);
        checkOutput("lvl_irq_c1", 32'(irqOut), 32'h0);
        tick(1);
        checkOutput("lvl_repend_irq", 32'(irqOut), 32'h1);

        // Asynchronous reset with two IDs in service and a third requesting
        doReset();
        busWrite(8'h20, 32'd2);
        busWrite(8'h24, 32'd4);
        busWrite(8'h28, 32'd6);
        busWrite(A_EN, 32'h07);
        busWrite(A_THR, 32'd1);
        srcIrq = 8'h01;
        tick(4);
        checkRead("ar_claim1", A_CLAIM, 32'd1);
        srcIrq = 8'h03;
        tick(4);
        checkRead("ar_claim2", A_CLAIM, 32'd2);
        srcIrq = 8'h07;
        tick(4);
        checkOutput("ar_irq_before", 32'(irqOut), 32'h1);
        #2 rst = 1'b1;
        #1 checkOutput("ar_irq_async", 32'(irqOut), 32'h0);
        srcIrq = 8'h00;
        tick(1);
        rst = 1'b0;
        checkRead("ar_pend", A_PEND, 32'h0);
        checkRead("ar_en", A_EN, 32'h0);
        checkRead("ar_thr", A_THR, 32'h0);
        checkRead("ar_insvc", A_INSVC, 32'h0);
        checkRead("ar_prio3", 8'h28, 32'h0);
        checkRead("ar_claim", A_CLAIM, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
